dec_port_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the 6-bit address predecoder port between four requesters. Each requester raises a request with its own address. The arbiter grants one requester at a time and drives the shared decoder address and enable. A hold counter bounds how long any one requester keeps the port, so no requester starves.

---
 rtl/dec_port_arbiter.sv | 98 +++++++++
 tb/tb_dec_port_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/dec_port_arbiter.sv
// Round-robin arbiter that shares the 6-bit address predecoder port between four requesters.
// Optional build macro ARB_PRIO0_EN: requester 0 wins every arbitration point without moving ptr.
module dec_port_lane #(
  parameter int ADDR_W = 6
) (
  input  logic              sel,
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] addr_q
);
  assign addr_q = sel ? addr : '0;
endmodule

module dec_port_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int HOLD_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic [4*ADDR_W-1:0]   addr_in,
  output logic [3:0]            gnt,
  output logic [ADDR_W-1:0]     dec_addr,
  output logic                  dec_en,
  output logic                  busy
);
  localparam int          NUM_LANES = 4;
  localparam logic [3:0]  HOLD_LAST = 4'(HOLD_MAX - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] hold_cnt;

  logic       arb, found, upd_ptr;
  logic [1:0] win;
  logic [NUM_LANES-1:0][ADDR_W-1:0] lane_addr;

  // Grant ends when the grantee drops its request or uses up its hold budget.
  always_comb begin
    arb     = (state == IDLE) || ((req & gnt) == 4'b0) || (hold_cnt == HOLD_LAST);
    found   = 1'b0;
    win     = ptr;
    upd_ptr = 1'b1;
    // Walk offsets from farthest to nearest so the nearest set bit after ptr wins.
    for (int k = NUM_LANES; k >= 1; k--) begin
      if (req[ptr + 2'(k)]) begin
        found = 1'b1;
        win   = ptr + 2'(k);
      end
    end
`ifdef ARB_PRIO0_EN
    if (req[0]) begin
      found   = 1'b1;
      win     = 2'd0;
      upd_ptr = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      ptr      <= 2'd3;
      hold_cnt <= 4'd0;
    end else if (arb) begin
      hold_cnt <= 4'd0;
      if (found) begin
        state <= GRANT;
        gnt   <= 4'b0001 << win;
        if (upd_ptr) ptr <= win;
      end else begin
        state <= IDLE;
        gnt   <= 4'b0000;
      end
    end else begin
      hold_cnt <= hold_cnt + 4'd1;
    end
  end

  // Address path is gated per lane by the registered grant, then OR-merged.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    dec_port_lane #(.ADDR_W(ADDR_W)) u_lane (
      .sel    (gnt[i]),
      .addr   (addr_in[i*ADDR_W +: ADDR_W]),
      .addr_q (lane_addr[i])
    );
  end

  always_comb begin
    dec_addr = '0;
    for (int i = 0; i < NUM_LANES; i++) dec_addr = dec_addr | lane_addr[i];
  end

  assign dec_en = |gnt;
  assign busy   = (state == GRANT);
endmodule

// File: tb/tb_dec_port_arbiter.sv
// Bench for dec_port_arbiter: directed vector table, async reset sequence, random traffic vs model.
module tb_dec_port_arbiter;
  localparam int AW = 6;
  localparam int HM = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req;
  logic [4*AW-1:0] addr_in;
  logic [3:0]      gnt;
  logic [AW-1:0]   dec_addr;
  logic            dec_en, busy;

  dec_port_arbiter #(.ADDR_W(AW), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst(rst), .req(req), .addr_in(addr_in),
    .gnt(gnt), .dec_addr(dec_addr), .dec_en(dec_en), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [3:0]  rq;
    logic [3:0]  g;
    logic [5:0]  a;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  // Reference model: current grantee, round-robin pointer, cycles used so far.
  int m_cur, m_ptr, m_used;
  bit m_busy;

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] g, input logic [5:0] a);
    vec_t v;
    v.r = r; v.rq = rq; v.g = g; v.a = a;
    tbl.push_back(v);
  endtask

  function automatic logic [5:0] addr_of(input int i);
    return addr_in[i*AW +: AW];
  endfunction

  task automatic chk(input string nm, input logic [3:0] eg, input logic [5:0] ea);
    nvec++;
    if (gnt !== eg || dec_addr !== ea || dec_en !== (|eg) || busy !== (|eg)) begin
      nerr++;
      $display("FAIL %s: got gnt=%b addr=%h en=%b busy=%b, want gnt=%b addr=%h en=%b busy=%b",
               nm, gnt, dec_addr, dec_en, busy, eg, ea, |eg, |eg);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_cur = 0; m_ptr = 3; m_used = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    bit ends;
    ends = !m_busy || !r[m_cur] || (m_used == HM);
    if (ends) begin
      m_busy = 0;
`ifdef ARB_PRIO0_EN
      if (r[0]) begin m_busy = 1; m_cur = 0; end
`endif
      for (int off = 1; off <= 4 && !m_busy; off++) begin
        int c;
        c = (m_ptr + off) % 4;
        if (r[c]) begin m_busy = 1; m_cur = c; m_ptr = c; end
      end
      m_used = m_busy ? 1 : 0;
    end else begin
      m_used++;
    end
  endtask

  initial begin
    rst = 1'b1; req = 4'b0; addr_in = '0;
    #12 rst = 1'b0;
    addr_in = {6'h3C, 6'h05, 6'h11, 6'h2A};

`ifdef ARB_PRIO0_EN
    add(1, 4'b0000, 4'b0000, 6'h00);
    add(0, 4'b0010, 4'b0010, 6'h11);
    repeat (3) add(0, 4'b0111, 4'b0010, 6'h11);
    add(0, 4'b0111, 4'b0001, 6'h2A);
    add(0, 4'b0110, 4'b0100, 6'h05);
`else
    add(1, 4'b0000, 4'b0000, 6'h00);
    repeat (6) add(0, 4'b0001, 4'b0001, 6'h2A);
    add(1, 4'b0000, 4'b0000, 6'h00);
    repeat (4) add(0, 4'b1111, 4'b0001, 6'h2A);
    repeat (4) add(0, 4'b1111, 4'b0010, 6'h11);
    repeat (4) add(0, 4'b1111, 4'b0100, 6'h05);
    repeat (4) add(0, 4'b1111, 4'b1000, 6'h3C);
    add(0, 4'b1111, 4'b0001, 6'h2A);
    add(1, 4'b0000, 4'b0000, 6'h00);
    repeat (2) add(0, 4'b0011, 4'b0001, 6'h2A);
    add(0, 4'b0010, 4'b0010, 6'h11);
    add(0, 4'b0000, 4'b0000, 6'h00);
`endif

    foreach (tbl[i]) begin
      rst = tbl[i].r;
      req = tbl[i].rq;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), tbl[i].g, tbl[i].a);
      rst = 1'b0;
    end

    // Reset asserted between edges must clear the port without a clock.
    req = 4'b0001;
    repeat (2) begin @(posedge clk); #1; chk("hold0", 4'b0001, 6'h2A); end
    #3 rst = 1'b1;
    #1 chk("async_rst", 4'b0000, 6'h00);
    #1 rst = 1'b0;
    req = 4'b1000;
    @(posedge clk); #1;
    chk("post_rst_first", 4'b1000, 6'h3C);

    rst = 1'b1; #1 rst = 1'b0;
    model_reset();
    for (int n = 0; n < 600; n++) begin
      logic [3:0] r;
      for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 99) < 55);
      req = r;
      addr_in = 24'($urandom);
      model_step(r);
      @(posedge clk); #1;
      chk("rand", m_busy ? (4'b0001 << m_cur) : 4'b0000, m_busy ? addr_of(m_cur) : 6'h00);
      if ($urandom_range(0, 59) == 0) begin
        #2 rst = 1'b1;
        #1 chk("rand_rst", 4'b0000, 6'h00);
        rst = 1'b0;
        model_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
